// File: rtl/sha3_result_arbiter.sv
// sha3_result_arbiter
// Shares one 64-bit result FIFO among several SHA3 cores. A finished core is
// granted round-robin, its 256-bit hash is captured into a local buffer, and
// the buffer is streamed to the FIFO as four 64-bit beats, low word first,
// stalling while the FIFO reports full.
module sha3_result_arbiter #(
    parameter int N_CORES = 4,
    parameter int ID_W    = $clog2(N_CORES),
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CORES-1:0]     core_valid_i,
    input  logic [N_CORES*256-1:0] core_hash_i,
    output logic [N_CORES-1:0]     core_ack_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_we_o,
    output logic [63:0]            fifo_dout_o,
    output logic [ID_W-1:0]        fifo_src_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       hash_count_o
);

    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_WRITE = 1'b1;
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_CORES - 1);

    logic [0:0]         state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    src_q, src_d;
    logic [255:0]       buffer_q, buffer_d;
    logic [1:0]         beat_q, beat_d;
    logic [N_CORES-1:0] ack_q, ack_d;
    logic [CNT_W-1:0]   hash_count_q, hash_count_d;

    logic               any_valid;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    scan_id;
    logic               write_en;
    logic [255:0]       hash_arr [N_CORES];

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_hash
        assign hash_arr[gi] = core_hash_i[gi*256 +: 256];
    end

    assign any_valid = |core_valid_i;

    // Round-robin pick: nearest requester after the last grant, scanning with wrap
    always_comb begin
        grant   = last_grant_q;
        scan_id = '0;
        for (int k = N_CORES; k >= 1; k--) begin
            scan_id = ID_W'((int'(last_grant_q) + k) % N_CORES);
            if (core_valid_i[scan_id]) begin
                grant = scan_id;
            end
        end
    end

    // A beat leaves only while transferring, FIFO has room and reset is not held
    assign write_en = (state_q == ST_WRITE) && !fifo_full_i && !rst;

    // Next-state logic for capture and beat serialization
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        buffer_d     = buffer_q;
        beat_d       = beat_q;
        ack_d        = '0;
        hash_count_d = hash_count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    buffer_d     = hash_arr[grant];
                    src_d        = grant;
                    last_grant_d = grant;
                    beat_d       = 2'd0;
                    ack_d[grant] = 1'b1;
                    state_d      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (write_en) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        hash_count_d = hash_count_q + CNT_W'(1);
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any partial transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_ID;
            src_q        <= '0;
            buffer_q     <= '0;
            beat_q       <= 2'd0;
            ack_q        <= '0;
            hash_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            buffer_q     <= buffer_d;
            beat_q       <= beat_d;
            ack_q        <= ack_d;
            hash_count_q <= hash_count_d;
        end
    end

    assign fifo_we_o    = write_en;
    assign fifo_dout_o  = write_en ? buffer_q[{beat_q, 6'd0} +: 64] : 64'd0;
    assign fifo_src_o   = write_en ? src_q : '0;
    assign busy_o       = (state_q == ST_WRITE) && !rst;
    assign core_ack_o   = rst ? '0 : ack_q;
    assign hash_count_o = rst ? '0 : hash_count_q;

endmodule

// File: tb/tb_sha3_result_arbiter.sv
// tb_sha3_result_arbiter
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a transaction-level model: a round-robin grant rule and a queue of
// expected FIFO words per granted hash.
module tb_sha3_result_arbiter;

    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       core_valid;
    logic [N*256-1:0]   core_hash;
    logic [N-1:0]       core_ack;
    logic               fifo_full;
    logic               fifo_we;
    logic [63:0]        fifo_dout;
    logic [ID_W-1:0]    fifo_src;
    logic               busy;
    logic [CNT_W-1:0]   hash_count;

    always #5 clk = ~clk;

    sha3_result_arbiter #(.N_CORES(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_valid_i (core_valid),
        .core_hash_i  (core_hash),
        .core_ack_o   (core_ack),
        .fifo_full_i  (fifo_full),
        .fifo_we_o    (fifo_we),
        .fifo_dout_o  (fifo_dout),
        .fifo_src_o   (fifo_src),
        .busy_o       (busy),
        .hash_count_o (hash_count)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // core-side stimulus
    logic [N-1:0]   coreValid;
    logic [255:0]   coreHash [N];
    logic           fullCmd;
    bit             holdValid;
    logic [N-1:0]   lastAck;

    // reference model
    logic [63:0]    expWords [$];
    int             expSrc;
    int             lastGrantM;
    logic [31:0]    countM;
    logic [N-1:0]   prevValid;
    logic [255:0]   prevHash [N];
    bit             prevDecide;

    // observation logs
    int             cycleNo;
    int             grantObs [$];
    int             ackCycles [$];
    logic [63:0]    obsWords [$];
    int             writeCount;
    logic [255:0]   t3Hash;

    function automatic logic [255:0] randHash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom();
        return h;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then check outputs
    task automatic applyStimulus(input bit doRst);
        logic [N-1:0] ackExp;
        bit           busyExp;
        bit           weExp;
        int           g;
        int           c;
        logic [63:0]  w;
        @(negedge clk);
        cycleNo++;
        for (int i = 0; i < N; i++) begin
            if (lastAck[i] && !holdValid) begin
                coreValid[i] = 1'b0;
                coreHash[i]  = randHash();
            end
        end
        rst        = doRst;
        fifo_full  = fullCmd;
        core_valid = coreValid;
        for (int i = 0; i < N; i++) core_hash[i*256 +: 256] = coreHash[i];
        #1;
        if (doRst) begin
            checkOutput("rst_we",    64'(fifo_we),    64'd0);
            checkOutput("rst_ack",   64'(core_ack),   64'd0);
            checkOutput("rst_busy",  64'(busy),       64'd0);
            checkOutput("rst_dout",  fifo_dout,       64'd0);
            checkOutput("rst_count", 64'(hash_count), 64'd0);
            expWords.delete();
            lastGrantM = N - 1;
            countM     = '0;
            prevDecide = 1'b0;
            lastAck    = '0;
            return;
        end
        ackExp = '0;
        if (prevDecide) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                c = (lastGrantM + k) % N;
                if (g < 0 && prevValid[c]) g = c;
            end
            ackExp[g]  = 1'b1;
            lastGrantM = g;
            expSrc     = g;
            for (int b = 0; b < 4; b++) expWords.push_back(prevHash[g][b*64 +: 64]);
        end
        checkOutput("ack", 64'(core_ack), 64'(ackExp));
        busyExp = (expWords.size() > 0);
        weExp   = busyExp && !fullCmd;
        checkOutput("busy",  64'(busy),       64'(busyExp));
        checkOutput("we",    64'(fifo_we),    64'(weExp));
        checkOutput("count", 64'(hash_count), 64'(countM));
        if (weExp) begin
            w = expWords.pop_front();
            checkOutput("dout", fifo_dout,      w);
            checkOutput("src",  64'(fifo_src),  64'(expSrc));
            if (expWords.size() == 0) countM = countM + 32'd1;
        end else begin
            checkOutput("dout_quiet", fifo_dout,     64'd0);
            checkOutput("src_quiet",  64'(fifo_src), 64'd0);
        end
        if (fifo_we) begin
            obsWords.push_back(fifo_dout);
            writeCount++;
        end
        if (core_ack != '0) begin
            for (int i = 0; i < N; i++) if (core_ack[i]) grantObs.push_back(i);
            ackCycles.push_back(cycleNo);
        end
        lastAck    = core_ack;
        prevDecide = !busyExp && (coreValid != '0);
        prevValid  = coreValid;
        prevHash   = coreHash;
    endtask

    // Withdraw all requests and let any transfer in flight finish
    task automatic drain();
        coreValid = '0;
        fullCmd   = 1'b0;
        for (int k = 0; k < 30 && (busy || prevDecide); k++) applyStimulus(1'b0);
        checkOutput("drain_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        fifo_full  = 1'b0;
        core_valid = '0;
        core_hash  = '0;
        coreValid  = '0;
        fullCmd    = 1'b0;
        holdValid  = 1'b0;
        lastAck    = '0;
        lastGrantM = N - 1;
        countM     = '0;
        prevDecide = 1'b0;
        prevValid  = '0;
        expSrc     = 0;
        cycleNo    = 0;
        writeCount = 0;
        for (int i = 0; i < N; i++) begin
            coreHash[i] = '0;
            prevHash[i] = '0;
        end

        // reset, then the first cycle after reset must be quiet
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);

        // single hash from core 2, words 1..4
        coreValid[2] = 1'b1;
        coreHash[2]  = {64'd4, 64'd3, 64'd2, 64'd1};
        obsWords.delete();
        grantObs.delete();
        writeCount = 0;
        for (int k = 0; k < 6; k++) applyStimulus(1'b0);
        checkOutput("t1_count",  64'(hash_count), 64'd1);
        checkOutput("t1_writes", 64'(writeCount), 64'd4);
        if (grantObs.size() == 1) checkOutput("t1_grant", 64'(grantObs[0]), 64'd2);
        else checkOutput("t1_grant_n", 64'(grantObs.size()), 64'd1);
        for (int i = 0; i < 4 && i < obsWords.size(); i++)
            checkOutput($sformatf("t1_word%0d", i), obsWords[i], 64'(i + 1));
        drain();

        // all cores requesting continuously for three rounds
        coreValid = '1;
        holdValid = 1'b1;
        for (int i = 0; i < N; i++) coreHash[i] = randHash();
        applyStimulus(1'b1);
        grantObs.delete();
        ackCycles.delete();
        for (int k = 0; k < 61; k++) applyStimulus(1'b0);
        checkOutput("t2_grants", 64'(grantObs.size()), 64'd12);
        for (int i = 0; i < 12 && i < grantObs.size(); i++)
            checkOutput($sformatf("t2_order%0d", i), 64'(grantObs[i]), 64'(i % 4));
        for (int i = 1; i < 12 && i < ackCycles.size(); i++)
            checkOutput($sformatf("t2_period%0d", i), 64'(ackCycles[i] - ackCycles[i-1]), 64'd5);
        checkOutput("t2_count", 64'(hash_count), 64'd12);
        holdValid = 1'b0;
        drain();

        // backpressure at beat 1, and the source changes its hash after capture
        t3Hash       = randHash();
        coreHash[1]  = t3Hash;
        coreValid[1] = 1'b1;
        obsWords.delete();
        grantObs.delete();
        writeCount = 0;
        for (int k = 0; k < 10 && grantObs.size() == 0; k++) applyStimulus(1'b0);
        checkOutput("t3_acked", 64'(grantObs.size()), 64'd1);
        fullCmd = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0);
        checkOutput("t3_stalled", 64'(writeCount), 64'd1);
        fullCmd = 1'b0;
        for (int k = 0; k < 10 && busy; k++) applyStimulus(1'b0);
        checkOutput("t3_writes", 64'(writeCount), 64'd4);
        for (int i = 0; i < 4 && i < obsWords.size(); i++)
            checkOutput($sformatf("t3_word%0d", i), obsWords[i], t3Hash[i*64 +: 64]);
        drain();

        // reset during beat 2, then core 0 must win over core 3
        coreValid[1] = 1'b1;
        coreHash[1]  = randHash();
        grantObs.delete();
        for (int k = 0; k < 10 && grantObs.size() == 0; k++) applyStimulus(1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        obsWords.delete();
        grantObs.delete();
        coreValid[0] = 1'b1;
        coreValid[3] = 1'b1;
        coreHash[0]  = randHash();
        coreHash[3]  = randHash();
        applyStimulus(1'b0);
        checkOutput("t5_noWrite", 64'(obsWords.size()), 64'd0);
        checkOutput("t5_count",   64'(hash_count),      64'd0);
        applyStimulus(1'b0);
        if (grantObs.size() > 0) checkOutput("t5_prio", 64'(grantObs[0]), 64'd0);
        else checkOutput("t5_prio_n", 64'(grantObs.size()), 64'd1);
        drain();

        // counter wrap from all-ones
        force dut.hash_count_q = '1;
        countM = 32'hFFFF_FFFF;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        release dut.hash_count_q;
        applyStimulus(1'b0);
        checkOutput("t6_preload", 64'(hash_count), 64'hFFFF_FFFF);
        coreValid[2] = 1'b1;
        coreHash[2]  = randHash();
        for (int k = 0; k < 7; k++) applyStimulus(1'b0);
        checkOutput("t6_wrap", 64'(hash_count), 64'd0);
        drain();

        // randomized requests, backpressure and occasional reset
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!coreValid[i] && $urandom_range(99) < 20) begin
                    coreValid[i] = 1'b1;
                    coreHash[i]  = randHash();
                end
            end
            fullCmd = ($urandom_range(99) < 30);
            applyStimulus($urandom_range(299) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
